// File: rtl/gmii_tx_frame_monitor.sv
// GMII transmit-side frame monitor: strips preamble/SFD, checks FCS and length,
// repacks frame bytes into 32-bit sop/eop/be words and keeps good/bad frame counters.
module gmii_tx_frame_monitor #(
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518,
  parameter bit STRICT_PRE = 1'b1
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic        tx_en,
  input  logic        tx_er,
  input  logic [7:0]  txd,
  output logic        mon_valid,
  output logic [31:0] mon_data,
  output logic [1:0]  mon_be,
  output logic        mon_sop,
  output logic        mon_eop,
  output logic        stat_valid,
  output logic [15:0] stat_len,
  output logic        stat_crc_ok,
  output logic [3:0]  stat_err,
  output logic [15:0] cnt_good,
  output logic [15:0] cnt_bad
);

  localparam logic [2:0]  S_IDLE = 3'd0;
  localparam logic [2:0]  S_PRE  = 3'd1;
  localparam logic [2:0]  S_DATA = 3'd2;
  localparam logic [2:0]  S_END  = 3'd3;
  localparam logic [2:0]  S_DROP = 3'd4;
  localparam logic [15:0] MIN_L  = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L  = 16'(MAX_LEN);
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  // CRC register is kept MSB-first; each byte is fed LSB-first as on the wire
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0]  state;
  logic        tx_en_d;
  logic [2:0]  pre_cnt;
  logic [31:0] crc;
  logic [15:0] len;
  logic [1:0]  idx;
  logic [31:0] acc;
  logic [31:0] held_word;
  logic        held_valid;
  logic        sop_pend;
  logic        er_seen;

  logic        start;
  logic [2:0]  start_state;
  logic        sfd_ok;
  logic        fin_crc_ok;
  logic [3:0]  fin_err;
  logic        fin_good;

  // Frame-start detection and end-of-frame verdict
  always_comb begin
    start       = tx_en & ~tx_en_d;
    start_state = (txd == 8'h55) ? S_PRE : S_DROP;
    sfd_ok      = STRICT_PRE ? (pre_cnt == 3'd7) : (pre_cnt != 3'd0);
    fin_crc_ok  = (crc == CRC_RESIDUE);
    fin_err     = {er_seen, (len > MAX_L), (len < MIN_L), 1'b0};
    fin_good    = fin_crc_ok & (fin_err == 4'b0000);
  end

  // Frame FSM, byte packing, status and counters
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      tx_en_d     <= 1'b1;
      pre_cnt     <= 3'd0;
      crc         <= 32'hFFFF_FFFF;
      len         <= 16'd0;
      idx         <= 2'd0;
      acc         <= 32'h0;
      held_word   <= 32'h0;
      held_valid  <= 1'b0;
      sop_pend    <= 1'b0;
      er_seen     <= 1'b0;
      mon_valid   <= 1'b0;
      mon_data    <= 32'h0;
      mon_be      <= 2'b00;
      mon_sop     <= 1'b0;
      mon_eop     <= 1'b0;
      stat_valid  <= 1'b0;
      stat_len    <= 16'd0;
      stat_crc_ok <= 1'b0;
      stat_err    <= 4'b0000;
      cnt_good    <= 16'd0;
      cnt_bad     <= 16'd0;
    end else begin
      tx_en_d     <= tx_en;
      mon_valid   <= 1'b0;
      mon_data    <= 32'h0;
      mon_be      <= 2'b00;
      mon_sop     <= 1'b0;
      mon_eop     <= 1'b0;
      stat_valid  <= 1'b0;
      stat_len    <= 16'd0;
      stat_crc_ok <= 1'b0;
      stat_err    <= 4'b0000;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= start_state;
            pre_cnt <= 3'd1;
          end
        end
        S_PRE: begin
          if (!tx_en) begin
            stat_valid <= 1'b1;
            stat_err   <= 4'b0001;
            cnt_bad    <= sat_inc(cnt_bad);
            state      <= S_IDLE;
          end else if (txd == 8'h55) begin
            if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
          end else if ((txd == 8'hD5) && sfd_ok) begin
            state      <= S_DATA;
            crc        <= 32'hFFFF_FFFF;
            len        <= 16'd0;
            idx        <= 2'd0;
            acc        <= 32'h0;
            held_valid <= 1'b0;
            sop_pend   <= 1'b1;
            er_seen    <= 1'b0;
          end else begin
            state <= S_DROP;
          end
        end
        S_DATA: begin
          if (tx_en) begin
            crc     <= crc32_byte(crc, txd);
            len     <= sat_inc(len);
            idx     <= idx + 2'd1;
            er_seen <= er_seen | tx_er;
            // A held full word is only known not to be last once another byte arrives
            if (held_valid) begin
              mon_valid  <= 1'b1;
              mon_data   <= held_word;
              mon_sop    <= sop_pend;
              sop_pend   <= 1'b0;
              held_valid <= 1'b0;
            end
            case (idx)
              2'd0:    acc <= {txd, 24'h0};
              2'd1:    acc[23:16] <= txd;
              2'd2:    acc[15:8] <= txd;
              2'd3: begin
                held_word  <= {acc[31:8], txd};
                held_valid <= 1'b1;
                acc        <= 32'h0;
              end
              default: acc <= acc;
            endcase
          end else begin
            state <= S_END;
          end
        end
        S_END: begin
          if (held_valid) begin
            mon_valid <= 1'b1;
            mon_data  <= held_word;
            mon_sop   <= sop_pend;
            mon_eop   <= 1'b1;
          end else if (idx != 2'd0) begin
            mon_valid <= 1'b1;
            mon_data  <= acc;
            mon_sop   <= sop_pend;
            mon_eop   <= 1'b1;
            mon_be    <= idx;
          end
          held_valid  <= 1'b0;
          sop_pend    <= 1'b0;
          stat_valid  <= 1'b1;
          stat_len    <= len;
          stat_crc_ok <= fin_crc_ok;
          stat_err    <= fin_err;
          if (fin_good) cnt_good <= sat_inc(cnt_good);
          else          cnt_bad  <= sat_inc(cnt_bad);
          // A 1-cycle IPG puts the next rising edge of tx_en into this cycle
          if (start) begin
            state   <= start_state;
            pre_cnt <= 3'd1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DROP: begin
          if (!tx_en) begin
            stat_valid <= 1'b1;
            stat_err   <= 4'b0001;
            cnt_bad    <= sat_inc(cnt_bad);
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
